// File: rtl/imem_loader.sv
// Boot-time program loader: assembles little-endian words from a byte stream,
// writes them into instruction memory and holds the core in reset until loaded.
module imem_loader #(
  parameter int WIDTH = 32,
  parameter int IADDR = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             reload,
  output logic             mem_wr_en,
  output logic [IADDR-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             core_reset_n,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int          BPW   = WIDTH / 8;
  localparam int          BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [31:0] DEPTH = 32'(2 ** IADDR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WRITE = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         r_n;
  logic [IADDR:0]     r_word_cnt;
  logic [BCW-1:0]     r_byte_cnt;
  logic [WIDTH-1:0]   r_word;
  logic               r_mem_wr_en;
  logic [IADDR-1:0]   r_mem_addr;
  logic [WIDTH-1:0]   r_mem_wdata;
  logic               r_core_reset_n;

  logic               w_accept;
  logic               w_last_byte;
  logic [BCW-1:0]     w_byte_inc;
  logic [IADDR:0]     w_cnt_inc;
  logic               w_cnt_done;
  logic [WIDTH-1:0]   w_word_nxt;

  assign in_ready     = (r_state == S_IDLE) || (r_state == S_LOAD);
  assign busy         = (r_state == S_LOAD) || (r_state == S_WRITE);
  assign done         = (r_state == S_DONE);
  assign err          = (r_state == S_ERR);
  assign mem_wr_en    = r_mem_wr_en;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign core_reset_n = r_core_reset_n;

  assign w_accept    = in_valid && in_ready;
  assign w_last_byte = (r_byte_cnt == BCW'(BPW - 1));
  assign w_byte_inc  = w_last_byte ? {BCW{1'b0}} : (r_byte_cnt + {{(BCW-1){1'b0}}, 1'b1});
  assign w_cnt_inc   = r_word_cnt + {{IADDR{1'b0}}, 1'b1};
  assign w_cnt_done  = (32'(w_cnt_inc) == 32'(r_n));

  // Assembly word with the incoming byte dropped into lane byte_cnt
  always_comb begin
    w_word_nxt = r_word;
    for (int b = 0; b < BPW; b++) begin
      if (r_byte_cnt == BCW'(b)) begin
        w_word_nxt[8*b +: 8] = in_data;
      end else begin
        w_word_nxt[8*b +: 8] = r_word[8*b +: 8];
      end
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!w_accept) begin
          w_state_nxt = S_IDLE;
        end else if (in_data == 8'd0) begin
          w_state_nxt = S_DONE;
        end else if ({24'd0, in_data} > DEPTH) begin
          w_state_nxt = S_ERR;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_accept && w_last_byte) begin
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_WRITE: begin
        if (w_cnt_done) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      S_DONE: begin
        if (reload) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, counters, assembly register and registered memory/core outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_n            <= 8'd0;
      r_word_cnt     <= '0;
      r_byte_cnt     <= '0;
      r_word         <= '0;
      r_mem_wr_en    <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_core_reset_n <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      // Strobe and core release follow the state being entered, so they line up with it
      r_mem_wr_en    <= (w_state_nxt == S_WRITE);
      r_core_reset_n <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_n        <= in_data;
            r_word_cnt <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_word     <= w_word_nxt;
            r_byte_cnt <= w_byte_inc;
            if (w_last_byte) begin
              r_mem_addr  <= r_word_cnt[IADDR-1:0];
              r_mem_wdata <= w_word_nxt;
            end
          end
        end
        S_WRITE: r_word_cnt <= w_cnt_inc;
        default: r_word_cnt <= r_word_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level
// model of the stream format and an emulated instruction memory.
module tb_imem_loader;

  localparam int WIDTH = 32;
  localparam int IADDR = 5;
  localparam int DEPTH = 2 ** IADDR;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             in_ready;
  logic             reload = 1'b0;
  logic             mem_wr_en;
  logic [IADDR-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic             core_reset_n;
  logic             busy;
  logic             done;
  logic             err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] words[$];
  int          act_a[$];
  logic [31:0] act_d[$];
  logic [31:0] img[DEPTH];
  logic [31:0] model_mem[DEPTH];

  imem_loader #(.WIDTH(WIDTH), .IADDR(IADDR)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .reload(reload), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .core_reset_n(core_reset_n),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Emulated instruction memory plus write log
  always @(negedge clk) begin
    if (reset_n && mem_wr_en) begin
      act_a.push_back(int'(mem_addr));
      act_d.push_back(mem_wdata);
      img[mem_addr] = mem_wdata;
      chk("wr_in_ready", {63'd0, in_ready}, 64'd0);
      chk("wr_core_rst", {63'd0, core_reset_n}, 64'd0);
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_wr_en"}, {63'd0, mem_wr_en}, 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_core_rst"}, {63'd0, core_reset_n}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_err"}, {63'd0, err}, 64'd0);
    chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t;
    if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("byte_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic fill_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom());
  endtask

  task automatic stream(input int n, input int nbytes, input bit gaps);
    send_byte(8'(n), gaps);
    for (int k = 0; k < nbytes; k++) send_byte(8'(words[k / 4] >> (8 * (k % 4))), gaps);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!done && !err && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("end_reached", {63'd0, (done | err)}, 64'd1);
  endtask

  // Compares the logged writes with words[0..nw-1] at addresses 0..nw-1
  task automatic compare_writes(input string tag, input int nw);
    chk({tag, "_nwrites"}, 64'(act_a.size()), 64'(nw));
    for (int i = 0; i < nw && i < act_a.size(); i++) begin
      chk({tag, "_addr"}, 64'(act_a[i]), 64'(i));
      chk({tag, "_data"}, 64'(act_d[i]), 64'(words[i]));
    end
    for (int i = 0; i < nw; i++) model_mem[i] = words[i];
    for (int a = 0; a < DEPTH; a++) chk({tag, "_mem"}, 64'(img[a]), 64'(model_mem[a]));
    act_a.delete();
    act_d.delete();
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    int n;
    for (int a = 0; a < DEPTH; a++) begin
      img[a] = 32'd0;
      model_mem[a] = 32'd0;
    end
    #1;
    check_reset_vals("rst0");
    @(negedge clk);
    reset_n = 1'b1;

    // Single word, back-to-back, with exact latency checks
    words.delete();
    words.push_back(32'h0010_0513);
    stream(1, 4, 1'b0);
    chk("t1_wr_en", {63'd0, mem_wr_en}, 64'd1);
    chk("t1_addr", 64'(mem_addr), 64'd0);
    chk("t1_wdata", 64'(mem_wdata), 64'h0010_0513);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    @(negedge clk);
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_core_rst", {63'd0, core_reset_n}, 64'd1);
    chk("t1_ready", {63'd0, in_ready}, 64'd0);
    chk("t1_wr_off", {63'd0, mem_wr_en}, 64'd0);
    compare_writes("t1", 1);

    pulse_reload();
    chk("rl_core_rst", {63'd0, core_reset_n}, 64'd0);
    chk("rl_ready", {63'd0, in_ready}, 64'd1);
    chk("rl_done", {63'd0, done}, 64'd0);

    // Three words with random gaps
    fill_words(3);
    stream(3, 12, 1'b1);
    wait_end();
    chk("t3_done", {63'd0, done}, 64'd1);
    compare_writes("t3", 3);

    // Empty program
    pulse_reload();
    send_byte(8'd0, 1'b0);
    chk("t0_done", {63'd0, done}, 64'd1);
    chk("t0_core_rst", {63'd0, core_reset_n}, 64'd1);
    chk("t0_busy", {63'd0, busy}, 64'd0);
    compare_writes("t0", 0);

    // Full memory, no wrap
    pulse_reload();
    fill_words(DEPTH);
    stream(DEPTH, DEPTH * 4, 1'b1);
    wait_end();
    chk("t32_done", {63'd0, done}, 64'd1);
    chk("t32_core_rst", {63'd0, core_reset_n}, 64'd1);
    compare_writes("t32", DEPTH);

    // Oversized count is terminal
    pulse_reload();
    send_byte(8'(DEPTH + 1), 1'b0);
    chk("t33_err", {63'd0, err}, 64'd1);
    chk("t33_ready", {63'd0, in_ready}, 64'd0);
    chk("t33_core_rst", {63'd0, core_reset_n}, 64'd0);
    pulse_reload();
    in_valid = 1'b1;
    in_data  = 8'h55;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("t33_err_hold", {63'd0, err}, 64'd1);
    chk("t33_core_hold", {63'd0, core_reset_n}, 64'd0);
    compare_writes("t33", 0);

    // Asynchronous reset part-way through the second word
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_err");
    @(negedge clk);
    reset_n = 1'b1;
    fill_words(2);
    stream(2, 6, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    @(negedge clk);
    reset_n = 1'b1;
    compare_writes("tmid", 1);
    fill_words(1);
    stream(1, 4, 1'b1);
    wait_end();
    compare_writes("tmid2", 1);

    // Reload and overwrite address 0
    pulse_reload();
    words.delete();
    words.push_back(32'hDEAD_BEEF);
    stream(1, 4, 1'b1);
    wait_end();
    chk("tdb_done", {63'd0, done}, 64'd1);
    compare_writes("tdb", 1);

    // A few random programs
    for (int r = 0; r < 3; r++) begin
      pulse_reload();
      n = $urandom_range(1, DEPTH);
      fill_words(n);
      stream(n, n * 4, 1'b1);
      wait_end();
      compare_writes("trand", n);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the single-cycle RISC-V core. It receives a byte stream over a valid/ready handshake and assembles little-endian instruction words. It writes those words into the instruction memory through its write port and holds the core in reset until the whole program is loaded. A reload request restarts the sequence without a system reset.

## Interface

Parameters:
- WIDTH, 32: instruction word width; must be a multiple of 8; BPW = WIDTH/8 bytes per word.
- IADDR, 5: instruction memory address width; depth = 2**IADDR words.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  byte on in_data is valid.
- in_data  in  8  stream byte.
- in_ready  out  1  loader accepts a byte this cycle; a transfer occurs on a rising edge with in_valid && in_ready.
- reload  in  1  single-cycle request to restart loading; honoured only in DONE.
- mem_wr_en  out  1  instruction memory write strobe.
- mem_addr  out  IADDR  instruction memory word address.
- mem_wdata  out  WIDTH  instruction memory write data.
- core_reset_n  out  1  active-low reset to the core; low while loading.
- busy  out  1  high in LOAD or WRITE.
- done  out  1  high in DONE.
- err  out  1  high in ERR.

## Operation

Stream format:
- Byte 0 is the word count N, unsigned 8 bits.
- It is followed by N*BPW payload bytes.
- The first byte of each word lands in bits [7:0], the next in [15:8], and so on.

States:
- IDLE (reset state): in_ready=1.
  - On the count byte with N=0: go to DONE.
  - With N > 2**IADDR: go to ERR.
  - Otherwise: latch N, clear the word counter and byte counter, go to LOAD.
- LOAD: in_ready=1.
  - Each accepted byte is shifted into the assembly register at lane byte_cnt; byte_cnt increments modulo BPW.
  - On the byte that completes a word (byte_cnt == BPW-1): go to WRITE.
  - Cycles with in_valid=0 hold all state.
- WRITE: in_ready=0.
  - mem_wr_en=1, mem_addr = word counter, mem_wdata = assembled word.
  - Next state: word counter increments. If the incremented count equals N, go to DONE; else go to LOAD.
- DONE: in_ready=0, core_reset_n=1.
  - reload=1 goes to IDLE and drives core_reset_n low on the same edge.
- ERR: in_ready=0, core_reset_n=0.
  - Terminal; only reset_n leaves it. reload is ignored.

Rules:
- The word counter is IADDR+1 bits wide so that N = 2**IADDR loads every address 0..2**IADDR-1 without wrap.
- Payload bytes arriving after N words are not accepted, because in_ready=0 in DONE.
- reload in any state other than DONE is ignored.

## Timing

Reset values, asserted asynchronously:
- state = IDLE.
- mem_wr_en = 0, mem_addr = 0, mem_wdata = 0.
- core_reset_n = 0.
- busy = 0, done = 0, err = 0.
- in_ready = 1 (IDLE decode).

Output timing:
- mem_wr_en, mem_addr, mem_wdata and core_reset_n are registered outputs.
- in_ready, busy, done and err are decoded from state only; none depends on in_valid.

Latency:
- The last byte of a word is accepted at edge k. WRITE occupies the cycle after edge k, and memory captures the word at edge k+1.
- For the last word, DONE and core_reset_n=1 become visible after edge k+1, i.e. the core leaves reset the cycle after the final memory write.
- Peak throughput is BPW bytes per BPW+1 cycles.

Reset mid-operation:
- reset_n low in any state returns to IDLE with the values above.
- A partially assembled word is discarded; words already written stay in memory.

## Test plan

- N=1, bytes 0x13,0x05,0x10,0x00 back-to-back -> one cycle with mem_wr_en=1, mem_addr=0, mem_wdata=0x00100513. The next cycle shows done=1 and core_reset_n=1, and in_ready=0.
- N=3 with random in_valid gaps, 12 payload bytes -> exactly three writes at addresses 0,1,2 with the correct little-endian words. in_ready is low during each WRITE cycle; no byte is lost or duplicated.
- N=0 -> done=1 after the count byte; zero writes; core_reset_n=1.
- N=32 -> 32 writes at addresses 0..31, no wrap, then DONE. N=33 -> err=1, in_ready=0, core_reset_n stays 0, no writes, reload ignored.
- reset_n pulsed low after 6 payload bytes of N=2 -> outputs return to reset values immediately. A fresh stream with N=1 then writes address 0 correctly.
- In DONE, reload=1 for one cycle -> core_reset_n=0 and in_ready=1 next cycle. A second stream with N=1 and word 0xDEADBEEF overwrites address 0 and returns to DONE.
